seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive-side counterpart to the 4-digit multiplexed seven-segment driver.
- Samples the active-low anode, cathode and dp lines that the driver produces, and rebuilds the four 4-bit digit values and dot flags.
- Used as a loopback monitor and self-check on Basys3 builds, and as the display checker in benches.
- Reports each complete scan frame with a strobe, an error flag and a staleness flag.

Parameters:
- SETTLE, 4, consecutive identical samples required before a digit is captured (range 1..255).
- TIMEOUT, 1024, cycles without an anode change before `stale` asserts (range 2..65535).

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst_n  in  1  synchronous active-low reset.
- an  in  4  anodes, active-low; {an3,an2,an1,an0}.
- seg  in  7  cathodes, active-low; {ca,cb,cc,cd,ce,cf,cg}.
- dp  in  1  decimal point, active-low.
- val3, val2, val1, val0  out  4 each  decoded digit values.
- dot3, dot2, dot1, dot0  out  1 each  decoded dot flags, active-high.
- frame_stb  out  1  one-cycle pulse when new values are published.
- frame_err  out  1  at least one undecodable pattern in the last published frame.
- stale  out  1  anode scan has stopped.

Behaviour:
- Reset, applied on any posedge with rst_n=0, including mid-frame:
  - All val and dot outputs go to 0; frame_stb, frame_err and stale go to 0.
  - The shadow registers, the seen mask, the settle counter and the timeout counter are all cleared.
  - The sample registers are loaded with an=4'b1111.
- Input stage: an, seg and dp are registered once into a_q, s_q and d_q. These sampled values are the only source for decode.
- Sample-stable tracking:
  - If {a_q,s_q,d_q} equals the previous cycle's value, settle_cnt increments, saturating at SETTLE.
  - Otherwise settle_cnt resets to 0.
- Anode legality: an is legal only when exactly one bit is 0. Legal patterns are 1110→digit0, 1101→digit1, 1011→digit2, 0111→digit3.
  - Any other pattern (1111, or two or more low bits) is never captured and settle_cnt is held at 0.
- Capture:
  - Happens in the cycle settle_cnt reaches SETTLE-1 with a legal anode.
  - It occurs once per anode visit; there is no recapture until the anode changes.
  - It writes shadow_val[idx], shadow_dot[idx]=~d_q and shadow_err[idx], and sets seen[idx].
  - Recapturing an already-seen digit overwrites its shadow entry.
- Segment decode: invert s_q to get active-high abcdefg, then map as follows.
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7.
  - 7F→8, 7B→9, 77→A, 4E→C, 4F→E, 47→F.
  - Values B and D are aliased by the encoder (onto 8 and 0) and are therefore never produced.
  - Any other pattern gives value 0 with shadow_err=1.
- Publish:
  - Occurs on the cycle after a capture that makes seen==4'b1111.
  - Shadow values copy to val3..val0 and dot3..dot0, frame_err=OR of shadow_err, and frame_stb=1 for exactly one cycle.
  - In the same cycle, seen and shadow_err clear.
  - Outputs hold until the next publish.
- Latency: publish follows the final digit's capture by 1 cycle. The final digit's capture happens SETTLE+1 cycles after its first appearance on the pins.
- Stale:
  - tmo_cnt resets to 0 whenever a_q changes; otherwise it increments, saturating.
  - stale=1 once tmo_cnt reaches TIMEOUT-1.
  - stale clears in the cycle after a_q changes.
  - stale does not alter the held values.
  - A frozen but legal anode keeps its one capture and does not publish.
- Simultaneous events: a capture and a publish never coincide, because publish is 1 cycle later. The anode changing in the publish cycle is captured normally into the freshly cleared seen mask.

Decomposition:
- Package seg7_pkg holds:
  - the active-high segment constants SEG_0..SEG_F;
  - the anode one-hot-low constants AN_D0..AN_D3;
  - a function seg_decode(7b) returning {err, val[3:0]}.
- Natural sub-module: seg7_pattern_decode (combinational seg_decode wrapper), instantiated once on s_q.
- The main block contains the input registers, settle counter, timeout counter, seen/shadow registers and publish logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with arbitrary inputs → all outputs 0; release with an=1111 → no frame_stb, and stale=1 after 1024 cycles.
- Clean frame: drive digits 0..3 with 1,2,3,4 (seg = ~30, ~6D, ~79, ~33), dp low on digit 2 only, each for 10 cycles → single frame_stb; val3..0=4,3,2,1; dot2=1, others 0; frame_err=0.
- Glitch rejection: on digit 1, drive seg=~7F for 2 cycles, then ~5B for 10 cycles (SETTLE=4) → val1=5, no error.
- Bad pattern: digit 3 drives seg=~00 → frame_err=1 on publish with val3=0; the next clean frame → frame_err=0.
- Illegal anode: insert an=1100 and an=1111 for 20 cycles between digits → no capture during those cycles; the frame still publishes once all four digits are seen.
- Reset mid-frame: capture digits 0 and 1, assert rst_n=0 for 1 cycle, then send digits 2, 3, 0, 1 → exactly one frame_stb, occurring after digit 1 is captured post-reset, not before.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and decode helpers for the seven-segment scan capture block.
// Segment constants are active-high {a,b,c,d,e,f,g}; anode constants are active-low one-hot.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  // The encoder draws B like 8 and D like 0, so these never decode back to B or D.
  localparam logic [6:0] SEG_B = SEG_8;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = SEG_0;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  localparam logic [3:0] AN_D0   = 4'b1110;
  localparam logic [3:0] AN_D1   = 4'b1101;
  localparam logic [3:0] AN_D2   = 4'b1011;
  localparam logic [3:0] AN_D3   = 4'b0111;
  localparam logic [3:0] AN_IDLE = 4'b1111;

  typedef struct packed {
    logic       err;
    logic [3:0] val;
  } seg_dec_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } an_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] seg_ah);
    seg_dec_t r;
    r = '0;
    case (seg_ah)
      SEG_0:   r.val = 4'h0;
      SEG_1:   r.val = 4'h1;
      SEG_2:   r.val = 4'h2;
      SEG_3:   r.val = 4'h3;
      SEG_4:   r.val = 4'h4;
      SEG_5:   r.val = 4'h5;
      SEG_6:   r.val = 4'h6;
      SEG_7:   r.val = 4'h7;
      SEG_8:   r.val = 4'h8;
      SEG_9:   r.val = 4'h9;
      SEG_A:   r.val = 4'hA;
      SEG_C:   r.val = 4'hC;
      SEG_E:   r.val = 4'hE;
      SEG_F:   r.val = 4'hF;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic an_dec_t an_decode(input logic [3:0] an);
    an_dec_t r;
    r = '0;
    case (an)
      AN_D0:   begin r.legal = 1'b1; r.idx = 2'd0; end
      AN_D1:   begin r.legal = 1'b1; r.idx = 2'd1; end
      AN_D2:   begin r.legal = 1'b1; r.idx = 2'd2; end
      AN_D3:   begin r.legal = 1'b1; r.idx = 2'd3; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Raw multiplexed display lines (all active-low) as driven by the scan driver.
interface seg7_scan_capture_if;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output an, seg, dp);
  modport slave  (input  an, seg, dp);
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational active-high segment pattern to hex digit decoder.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_ah,
  output logic [3:0] val,
  output logic       err
);

  seg_dec_t dec;

  assign dec = seg_decode(seg_ah);
  assign val = dec.val;
  assign err = dec.err;

endmodule

// File: rtl/seg7_scan_capture.sv
// Rebuilds the four digit values and dots from a sampled 4-digit scan,
// publishing each complete frame with a strobe, an error flag and a stale flag.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_capture_if.slave scan,
  output logic [3:0]         val3,
  output logic [3:0]         val2,
  output logic [3:0]         val1,
  output logic [3:0]         val0,
  output logic               dot3,
  output logic               dot2,
  output logic               dot1,
  output logic               dot0,
  output logic               frame_stb,
  output logic               frame_err,
  output logic               stale
);

  localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE);
  localparam logic [7:0]  SETTLE_CAP = 8'(SETTLE - 1);
  localparam logic [15:0] TMO_MAX    = 16'(TIMEOUT - 1);

  logic [3:0]  a_q, a_p;
  logic [6:0]  s_q, s_p, s_ah;
  logic        d_q, d_p;
  logic [7:0]  settle_cnt, settle_next;
  logic [15:0] tmo_cnt;
  logic        visit_cap;
  logic [3:0]  seen, seen_base, cap_mask;
  logic        pub_pend;
  logic        a_chg, same, capture;
  an_dec_t     an_dec;
  logic [3:0]  dec_val;
  logic        dec_err;
  logic [15:0] val_w;
  logic [3:0]  dot_w, shadow_err_w;
  logic        frame_stb_reg, frame_err_reg;

  // a_p/s_p/d_p hold the previous sample so stability is judged on registered data only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= AN_IDLE;
      s_q <= 7'h7F;
      d_q <= 1'b1;
      a_p <= AN_IDLE;
      s_p <= 7'h7F;
      d_p <= 1'b1;
    end else begin
      a_q <= scan.an;
      s_q <= scan.seg;
      d_q <= scan.dp;
      a_p <= a_q;
      s_p <= s_q;
      d_p <= d_q;
    end
  end

  assign an_dec = an_decode(a_q);
  assign a_chg  = (a_q != a_p);
  assign same   = ({a_q, s_q, d_q} == {a_p, s_p, d_p});
  assign s_ah   = ~s_q;

  seg7_pattern_decode u_decode (
    .seg_ah (s_ah),
    .val    (dec_val),
    .err    (dec_err)
  );

  always_comb begin
    settle_next = 8'd0;
    if (an_dec.legal && same) begin
      settle_next = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + 8'd1;
    end
  end

  // One capture per anode visit: visit_cap blocks re-arming until the anode moves.
  assign capture   = an_dec.legal && (settle_next == SETTLE_CAP) && !(visit_cap && !a_chg);
  assign cap_mask  = capture ? (4'b0001 << an_dec.idx) : 4'b0000;
  assign seen_base = pub_pend ? 4'b0000 : seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt    <= 8'd0;
      tmo_cnt       <= 16'd0;
      visit_cap     <= 1'b0;
      seen          <= 4'b0000;
      pub_pend      <= 1'b0;
      frame_stb_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      settle_cnt <= settle_next;
      if (a_chg) begin
        tmo_cnt <= 16'd0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (capture) begin
        visit_cap <= 1'b1;
      end else if (a_chg) begin
        visit_cap <= 1'b0;
      end
      seen          <= seen_base | cap_mask;
      pub_pend      <= capture && ((seen_base | cap_mask) == 4'hF);
      frame_stb_reg <= pub_pend;
      if (pub_pend) begin
        frame_err_reg <= |shadow_err_w;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] shadow_val_reg, pub_val_reg;
    logic       shadow_dot_reg, shadow_err_reg, pub_dot_reg;
    logic       hit;

    assign hit = cap_mask[gi];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shadow_val_reg <= 4'h0;
        shadow_dot_reg <= 1'b0;
        shadow_err_reg <= 1'b0;
        pub_val_reg    <= 4'h0;
        pub_dot_reg    <= 1'b0;
      end else begin
        if (hit) begin
          shadow_val_reg <= dec_val;
          shadow_dot_reg <= ~d_q;
        end
        if (hit) begin
          shadow_err_reg <= dec_err;
        end else if (pub_pend) begin
          shadow_err_reg <= 1'b0;
        end
        if (pub_pend) begin
          pub_val_reg <= shadow_val_reg;
          pub_dot_reg <= shadow_dot_reg;
        end
      end
    end

    assign val_w[gi*4 +: 4] = pub_val_reg;
    assign dot_w[gi]        = pub_dot_reg;
    assign shadow_err_w[gi] = shadow_err_reg;
  end

  assign {val3, val2, val1, val0} = val_w;
  assign {dot3, dot2, dot1, dot0} = dot_w;
  assign frame_stb = frame_stb_reg;
  assign frame_err = frame_err_reg;
  assign stale     = (tmo_cnt == TMO_MAX);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: a frame-level reference model is compared
// against the outputs every cycle, plus literal checks at the end of each scenario.
module tb_seg7_scan_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] val3, val2, val1, val0;
  logic       dot3, dot2, dot1, dot0;
  logic       frame_stb, frame_err, stale;

  int n_checks = 0;
  int n_errors = 0;
  int stb_cnt  = 0;

  seg7_scan_capture_if scan ();

  seg7_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan      (scan),
    .val3      (val3),
    .val2      (val2),
    .val1      (val1),
    .val0      (val0),
    .dot3      (dot3),
    .dot2      (dot2),
    .dot1      (dot1),
    .dot0      (dot0),
    .frame_stb (frame_stb),
    .frame_err (frame_err),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference glyph table, indexed by digit value; B and D have no glyph of their own.
  function automatic logic [6:0] ref_glyph(input int v);
    case (v)
      0: return 7'h7E;   1: return 7'h30;   2: return 7'h6D;   3: return 7'h79;
      4: return 7'h33;   5: return 7'h5B;   6: return 7'h5F;   7: return 7'h70;
      8: return 7'h7F;   9: return 7'h7B;  10: return 7'h77;  12: return 7'h4E;
      14: return 7'h4F; 15: return 7'h47;
      default: return 7'h00;
    endcase
  endfunction

  typedef struct {
    int          at;
    logic [15:0] v;
    logic [3:0]  d;
    logic        e;
  } pub_t;

  pub_t        pubq[$];
  int          e_cnt = 0;
  int          zero_edge = 0;
  int          run_len = 0;
  logic [11:0] last_t;
  logic [3:0]  last_an;
  bit          visit_done;
  bit          valid = 0;
  logic [3:0]  m_seen;
  logic [3:0]  m_val[4];
  logic        m_dot[4];
  logic        m_err[4];
  logic [15:0] exp_val;
  logic [3:0]  exp_dot;
  logic        exp_stb, exp_err, exp_stale;

  // Model: a digit is taken once SETTLE identical pin samples have been seen on a
  // legal anode; the outputs show the frame two clocks after its last digit's sample.
  always @(posedge clk) begin
    logic [11:0] t;
    int          idx;
    logic [3:0]  dv;
    logic        de;
    pub_t        p;
    e_cnt++;
    if (!rst_n) begin
      valid      = 1;
      last_t     = {4'hF, 7'h7F, 1'b1};
      last_an    = 4'hF;
      run_len    = 0;
      visit_done = 0;
      m_seen     = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 4'h0; m_dot[i] = 1'b0; m_err[i] = 1'b0;
      end
      pubq.delete();
      exp_val = 16'h0; exp_dot = 4'h0; exp_stb = 0; exp_err = 0; exp_stale = 0;
      zero_edge = e_cnt;
    end else begin
      t = {scan.an, scan.seg, scan.dp};
      exp_stale = (e_cnt - zero_edge) >= (TIMEOUT - 1);
      if (scan.an != last_an) begin
        zero_edge  = e_cnt + 1;
        visit_done = 0;
      end
      run_len = (t == last_t) ? ((run_len < 100000) ? run_len + 1 : run_len) : 1;
      if ($countones(~scan.an) == 1 && run_len == SETTLE && !visit_done) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!scan.an[i]) idx = i;
        dv = 4'h0;
        de = 1'b1;
        for (int v = 0; v < 16; v++) begin
          if (v != 11 && v != 13 && ref_glyph(v) == ~scan.seg) begin
            dv = 4'(v);
            de = 1'b0;
          end
        end
        m_val[idx] = dv;
        m_dot[idx] = ~scan.dp;
        m_err[idx] = de;
        m_seen[idx] = 1'b1;
        visit_done = 1;
        if (m_seen == 4'hF) begin
          p.at = e_cnt + 2;
          p.v  = {m_val[3], m_val[2], m_val[1], m_val[0]};
          p.d  = {m_dot[3], m_dot[2], m_dot[1], m_dot[0]};
          p.e  = m_err[0] | m_err[1] | m_err[2] | m_err[3];
          pubq.push_back(p);
          m_seen = 4'h0;
        end
      end
      last_t  = t;
      last_an = scan.an;
      exp_stb = 0;
      if (pubq.size() > 0 && pubq[0].at == e_cnt) begin
        exp_val = pubq[0].v;
        exp_dot = pubq[0].d;
        exp_err = pubq[0].e;
        exp_stb = 1;
        void'(pubq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("val", int'({val3, val2, val1, val0}), int'(exp_val));
      chk("dot", int'({dot3, dot2, dot1, dot0}), int'(exp_dot));
      chk("frame_stb", int'(frame_stb), int'(exp_stb));
      chk("frame_err", int'(frame_err), int'(exp_err));
      chk("stale", int'(stale), int'(exp_stale));
      if (frame_stb) stb_cnt++;
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg_ah, input logic dot, input int n);
    scan.an  = an;
    scan.seg = ~seg_ah;
    scan.dp  = ~dot;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame4(input logic [6:0] g0, input logic [6:0] g1,
                        input logic [6:0] g2, input logic [6:0] g3, input logic [3:0] dots);
    drive(4'b1110, g0, dots[0], 10);
    drive(4'b1101, g1, dots[1], 10);
    drive(4'b1011, g2, dots[2], 10);
    drive(4'b0111, g3, dots[3], 10);
  endtask

  task automatic lit_frame(input string name, input logic [15:0] v, input logic [3:0] d,
                           input logic e, input int stb_delta, input int stb_start);
    $display("frame %s: val=%h dot=%b err=%0d stb=%0d", name,
             {val3, val2, val1, val0}, {dot3, dot2, dot1, dot0}, frame_err, stb_cnt - stb_start);
    chk({name, "_val"}, int'({val3, val2, val1, val0}), int'(v));
    chk({name, "_dot"}, int'({dot3, dot2, dot1, dot0}), int'(d));
    chk({name, "_err"}, int'(frame_err), int'(e));
    chk({name, "_stb"}, stb_cnt - stb_start, stb_delta);
  endtask

  initial begin
    int s0;
    rst_n    = 1'b0;
    scan.an  = 4'b1001;
    scan.seg = 7'h15;
    scan.dp  = 1'b0;
    repeat (3) @(negedge clk);
    lit_frame("reset", 16'h0000, 4'h0, 1'b0, 0, 0);
    chk("reset_stale", int'(stale), 0);

    rst_n = 1'b1;
    drive(4'b1111, 7'h00, 1'b0, 1000);
    chk("idle_not_stale", int'(stale), 0);
    drive(4'b1111, 7'h00, 1'b0, 30);
    chk("idle_stale", int'(stale), 1);
    chk("idle_no_stb", stb_cnt, 0);

    s0 = stb_cnt;
    frame4(7'h30, 7'h6D, 7'h79, 7'h33, 4'b0100);
    drive(4'b1111, 7'h00, 1'b0, 5);
    lit_frame("clean", 16'h4321, 4'b0100, 1'b0, 1, s0);
    chk("clean_stale", int'(stale), 0);

    s0 = stb_cnt;
    drive(4'b1110, 7'h70, 1'b0, 10);
    drive(4'b1101, 7'h7F, 1'b0, 2);
    drive(4'b1101, 7'h5B, 1'b0, 10);
    drive(4'b1011, 7'h7B, 1'b0, 10);
    drive(4'b0111, 7'h77, 1'b1, 10);
    drive(4'b1111, 7'h00, 1'b0, 5);
    lit_frame("glitch", 16'hA957, 4'b1000, 1'b0, 1, s0);

    s0 = stb_cnt;
    frame4(7'h7E, 7'h5F, 7'h7F, 7'h00, 4'b0000);
    drive(4'b1111, 7'h00, 1'b0, 5);
    lit_frame("badpat", 16'h0860, 4'b0000, 1'b1, 1, s0);
    s0 = stb_cnt;
    frame4(7'h4E, 7'h4F, 7'h47, 7'h30, 4'b0011);
    drive(4'b1111, 7'h00, 1'b0, 5);
    lit_frame("recover", 16'h1FEC, 4'b0011, 1'b0, 1, s0);

    s0 = stb_cnt;
    drive(4'b1110, 7'h33, 1'b0, 10);
    drive(4'b1100, 7'h6D, 1'b0, 20);
    drive(4'b1101, 7'h79, 1'b0, 10);
    drive(4'b1111, 7'h6D, 1'b0, 20);
    drive(4'b1011, 7'h5B, 1'b0, 10);
    chk("illegal_no_early_stb", stb_cnt - s0, 0);
    drive(4'b0111, 7'h70, 1'b0, 10);
    drive(4'b1111, 7'h00, 1'b0, 5);
    lit_frame("illegal", 16'h7534, 4'b0000, 1'b0, 1, s0);

    s0 = stb_cnt;
    drive(4'b1110, 7'h30, 1'b0, 10);
    drive(4'b1101, 7'h6D, 1'b0, 10);
    rst_n = 1'b0;
    drive(4'b1111, 7'h00, 1'b0, 1);
    rst_n = 1'b1;
    lit_frame("midreset", 16'h0000, 4'b0000, 1'b0, 0, s0);
    drive(4'b1011, 7'h79, 1'b0, 10);
    drive(4'b0111, 7'h33, 1'b0, 10);
    drive(4'b1110, 7'h5F, 1'b1, 10);
    chk("midreset_no_early_stb", stb_cnt - s0, 0);
    drive(4'b1101, 7'h70, 1'b0, 10);
    drive(4'b1111, 7'h00, 1'b0, 5);
    lit_frame("postreset", 16'h4376, 4'b0001, 1'b0, 1, s0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
